// File: rtl/audio_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : audio_pkg
//  Brief    : Shared constants and helpers for the I2S audio transmitter
//  Revision : 1.0 - initial release
// ============================================================================
package audio_pkg;

  // Serial formats
  localparam int FMT_I2S = 0;  // Philips I2S: MSB one BCLK after LRCK edge
  localparam int FMT_LJ  = 1;  // left-justified: MSB coincident with LRCK edge

  localparam int SAMPLE_W      = 16;
  localparam int BCLK_HALF_DEF = 7;
  localparam int SLOT_BITS_DEF = 32;

  // Frame bit counter width: holds 0..2*SLOT_BITS-1 for SLOT_BITS up to 32
  localparam int CNT_W = 6;

  // Bit driven at slot position pos. In I2S mode the word is delayed one BCLK,
  // so pos 0 underflows to a large index and yields the zero pad.
  function automatic logic slot_bit(input logic [SAMPLE_W-1:0] smp,
                                    input logic [CNT_W-1:0]    pos,
                                    input logic                fmt_lj);
    logic [CNT_W-1:0]    b;
    logic [SAMPLE_W-1:0] shifted;
    b        = fmt_lj ? pos : pos - CNT_W'(1);
    shifted  = smp << b;
    slot_bit = (b < CNT_W'(SAMPLE_W)) ? shifted[SAMPLE_W-1] : 1'b0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/audio_clk_gen.sv
`default_nettype none
// ============================================================================
//  Module   : audio_clk_gen
//  Brief    : MCLK / BCLK generation from clk_vga with BCLK edge enables
//  Revision : 1.0 - initial release
// ============================================================================
module audio_clk_gen
  import audio_pkg::*;
#(
  parameter int BCLK_HALF = BCLK_HALF_DEF
) (
  input  logic clk_vga,
  input  logic reset_wire,
  output logic mclk_o,
  output logic bclk_o,
  output logic rise_en_o,
  output logic fall_en_o
);

  localparam int               DIV_W    = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_HALF - 1);

  logic [DIV_W-1:0] div_cnt_q;
  logic             mclk_q;
  logic             bclk_q;
  logic             wrap;

  assign wrap = (div_cnt_q == DIV_LAST);

  // Free-running divider: MCLK toggles every cycle, BCLK toggles at divider wrap
  always_ff @(posedge clk_vga or posedge reset_wire) begin
    if (reset_wire) begin
      div_cnt_q <= '0;
      mclk_q    <= 1'b0;
      bclk_q    <= 1'b0;
    end else begin
      mclk_q    <= ~mclk_q;
      div_cnt_q <= wrap ? '0 : div_cnt_q + DIV_W'(1);
      if (wrap) begin
        bclk_q <= ~bclk_q;
      end
    end
  end

  // Enables are high in the cycle whose closing edge moves BCLK to 1 / 0
  assign rise_en_o = wrap & ~bclk_q;
  assign fall_en_o = wrap &  bclk_q;
  assign mclk_o    = mclk_q;
  assign bclk_o    = bclk_q;

endmodule
`default_nettype wire

// File: rtl/audio_i2s_tx.sv
`default_nettype none
// ============================================================================
//  Module   : audio_i2s_tx
//  Brief    : Stereo 16-bit I2S / left-justified serialiser for external DAC
//  Revision : 1.0 - initial release
// ============================================================================
// reset_wire asserts asynchronously; the upstream reset generator already
// deasserts it synchronously to clk_vga, so no local synchroniser is added.
module audio_i2s_tx
  import audio_pkg::*;
#(
  parameter int BCLK_HALF = BCLK_HALF_DEF,
  parameter int FORMAT    = FMT_I2S,
  parameter int SLOT_BITS = SLOT_BITS_DEF
) (
  input  logic                clk_vga,
  input  logic                reset_wire,
  input  logic [SAMPLE_W-1:0] aud_l,
  input  logic [SAMPLE_W-1:0] aud_r,
  input  logic                mute,
  output logic                i2s_mclk,
  output logic                i2s_bclk,
  output logic                i2s_lrck,
  output logic                i2s_sdata,
  output logic                frame_strobe
);

  localparam logic [CNT_W-1:0] SLOT_LEN  = CNT_W'(SLOT_BITS);
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(2 * SLOT_BITS - 1);
  localparam logic             FMT_IS_LJ = (FORMAT == FMT_LJ);

  logic fall_en;
  logic rise_en_unused;   // transmitter works purely on BCLK falls

  audio_clk_gen #(
    .BCLK_HALF (BCLK_HALF)
  ) u_clk_gen (
    .clk_vga    (clk_vga),
    .reset_wire (reset_wire),
    .mclk_o     (i2s_mclk),
    .bclk_o     (i2s_bclk),
    .rise_en_o  (rise_en_unused),
    .fall_en_o  (fall_en)
  );

  // ---------------------------------------------------------------- input CDC
  logic [SAMPLE_W-1:0] l_s1_q, l_s2_q, l_s3_q, cand_l_q;
  logic [SAMPLE_W-1:0] r_s1_q, r_s2_q, r_s3_q, cand_r_q;
  logic                stable_l, stable_r;

  assign stable_l = (l_s2_q == l_s3_q);
  assign stable_r = (r_s2_q == r_s3_q);

  // Sample both channels through two flops; candidate follows only when settled
  always_ff @(posedge clk_vga or posedge reset_wire) begin
    if (reset_wire) begin
      l_s1_q   <= '0;
      l_s2_q   <= '0;
      l_s3_q   <= '0;
      cand_l_q <= '0;
      r_s1_q   <= '0;
      r_s2_q   <= '0;
      r_s3_q   <= '0;
      cand_r_q <= '0;
    end else begin
      l_s1_q <= aud_l;
      l_s2_q <= l_s1_q;
      l_s3_q <= l_s2_q;
      r_s1_q <= aud_r;
      r_s2_q <= r_s1_q;
      r_s3_q <= r_s2_q;
      if (stable_l) begin
        cand_l_q <= l_s2_q;
      end
      if (stable_r) begin
        cand_r_q <= r_s2_q;
      end
    end
  end

  // --------------------------------------------------------------- serialiser
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [SAMPLE_W-1:0] held_l_q, held_l_d;
  logic [SAMPLE_W-1:0] held_r_q, held_r_d;
  logic                lrck_q, sdata_q, strobe_q;
  logic                frame_end;
  logic                slot_right;
  logic [CNT_W-1:0]    pos;
  logic                sdata_d;

  // Next frame position, pair latch at frame end, and the bit it puts on the pin
  always_comb begin
    bit_cnt_d  = (bit_cnt_q == LAST_BIT) ? '0 : bit_cnt_q + CNT_W'(1);
    frame_end  = fall_en && (bit_cnt_q == LAST_BIT);
    held_l_d   = held_l_q;
    held_r_d   = held_r_q;
    if (frame_end) begin
      held_l_d = mute ? '0 : cand_l_q;
      held_r_d = mute ? '0 : cand_r_q;
    end
    // lrck and data both follow the post-increment position so they move together
    slot_right = (bit_cnt_d >= SLOT_LEN);
    pos        = slot_right ? (bit_cnt_d - SLOT_LEN) : bit_cnt_d;
    sdata_d    = slot_bit(slot_right ? held_r_d : held_l_d, pos, FMT_IS_LJ);
  end

  // Advance the frame and update pins on each BCLK fall; strobe marks a new pair
  always_ff @(posedge clk_vga or posedge reset_wire) begin
    if (reset_wire) begin
      bit_cnt_q <= '0;
      held_l_q  <= '0;
      held_r_q  <= '0;
      lrck_q    <= 1'b0;
      sdata_q   <= 1'b0;
      strobe_q  <= 1'b0;
    end else begin
      strobe_q <= frame_end;
      if (fall_en) begin
        bit_cnt_q <= bit_cnt_d;
        held_l_q  <= held_l_d;
        held_r_q  <= held_r_d;
        lrck_q    <= slot_right;
        sdata_q   <= sdata_d;
      end
    end
  end

  assign i2s_lrck     = lrck_q;
  assign i2s_sdata    = sdata_q;
  assign frame_strobe = strobe_q;

endmodule
`default_nettype wire
